// File: rtl/alu_ctrl_pipe.sv
// rtl/alu_ctrl_pipe.sv - ALU control decode with a 2-entry registered skid buffer.
// Optional feature: define ALUCTRL_SLLV_EN to decode sllv (funct 000100) with shamt from rs_lo.
module alu_ctrl_pipe #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       aluop,
   input  logic [5:0]       funct,
   input  logic [4:0]       shamt_in,
   input  logic [4:0]       rs_lo,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       F,
   output logic [4:0]       shamt,
   output logic [TAG_W-1:0] tag_out,
   output logic             illegal
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           state_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [3:0]       head_f_q;
   logic [4:0]       head_shamt_q;
   logic [TAG_W-1:0] head_tag_q;
   logic             head_ill_q;
   logic [3:0]       sec_f_q;
   logic [4:0]       sec_shamt_q;
   logic [TAG_W-1:0] sec_tag_q;
   logic             sec_ill_q;

   logic [3:0] f_d;
   logic [4:0] shamt_d;
   logic       ill_d;
   logic       push;
   logic       pop;

   always_comb begin
      f_d     = 4'b0010;
      shamt_d = 5'd0;
      ill_d   = 1'b0;
      unique case (aluop)
         2'b00: f_d = 4'b0010;
         2'b01: f_d = 4'b1010;
         2'b11: f_d = 4'b0001;
         default: begin
            unique case (funct)
               6'b100000: f_d = 4'b0010;
               6'b100010: f_d = 4'b1010;
               6'b100100: f_d = 4'b0000;
               6'b100101: f_d = 4'b0001;
               6'b101010: f_d = 4'b1011;
               6'b000000: begin
                  f_d     = 4'b0100;
                  shamt_d = shamt_in;
               end
`ifdef ALUCTRL_SLLV_EN
               6'b000100: begin
                  f_d     = 4'b0100;
                  shamt_d = rs_lo;
               end
`endif
               default: begin
                  f_d   = 4'b0010;
                  ill_d = 1'b1;
               end
            endcase
         end
      endcase
   end

`ifndef ALUCTRL_SLLV_EN
   logic unused_rs_lo;
   assign unused_rs_lo = ^rs_lo;
`endif

   assign push = in_valid & in_ready_q;
   assign pop  = out_valid_q & out_ready;

   // Head registers are cleared whenever the buffer drains so outputs read 0 when empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_EMPTY;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         head_f_q     <= '0;
         head_shamt_q <= '0;
         head_tag_q   <= '0;
         head_ill_q   <= 1'b0;
         sec_f_q      <= '0;
         sec_shamt_q  <= '0;
         sec_tag_q    <= '0;
         sec_ill_q    <= 1'b0;
      end else if (flush) begin
         state_q      <= ST_EMPTY;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         head_f_q     <= '0;
         head_shamt_q <= '0;
         head_tag_q   <= '0;
         head_ill_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  state_q      <= ST_ONE;
                  out_valid_q  <= 1'b1;
                  head_f_q     <= f_d;
                  head_shamt_q <= shamt_d;
                  head_tag_q   <= tag_in;
                  head_ill_q   <= ill_d;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  head_f_q     <= f_d;
                  head_shamt_q <= shamt_d;
                  head_tag_q   <= tag_in;
                  head_ill_q   <= ill_d;
               end else if (push) begin
                  state_q     <= ST_FULL;
                  in_ready_q  <= 1'b0;
                  sec_f_q     <= f_d;
                  sec_shamt_q <= shamt_d;
                  sec_tag_q   <= tag_in;
                  sec_ill_q   <= ill_d;
               end else if (pop) begin
                  state_q      <= ST_EMPTY;
                  out_valid_q  <= 1'b0;
                  head_f_q     <= '0;
                  head_shamt_q <= '0;
                  head_tag_q   <= '0;
                  head_ill_q   <= 1'b0;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  state_q      <= ST_ONE;
                  in_ready_q   <= 1'b1;
                  head_f_q     <= sec_f_q;
                  head_shamt_q <= sec_shamt_q;
                  head_tag_q   <= sec_tag_q;
                  head_ill_q   <= sec_ill_q;
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign F         = head_f_q;
   assign shamt     = head_shamt_q;
   assign tag_out   = head_tag_q;
   assign illegal   = head_ill_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// tb/tb_alu_ctrl_pipe.sv - directed self-checking bench for alu_ctrl_pipe.
module tb_alu_ctrl_pipe;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] aluop;
   logic [5:0] funct;
   logic [4:0] shamt_in;
   logic [4:0] rs_lo;
   logic [4:0] tag_in;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] F;
   logic [4:0] shamt;
   logic [4:0] tag_out;
   logic       illegal;

   int n_cmp = 0;
   int n_bad = 0;

   alu_ctrl_pipe #(.TAG_W(5)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .aluop(aluop), .funct(funct), .shamt_in(shamt_in), .rs_lo(rs_lo), .tag_in(tag_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .F(F), .shamt(shamt), .tag_out(tag_out), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [4:0] tg);
      in_valid = 1'b1;
      aluop    = op;
      funct    = fn;
      shamt_in = sh;
      tag_in   = tg;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      aluop = 2'b00; funct = 6'd0; shamt_in = 5'd0; rs_lo = 5'd0; tag_in = 5'd0;
      step();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_F", {28'd0, F}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      reset = 1'b0;
      step();

      // sub R-type, one-cycle latency
      out_ready = 1'b1;
      offer(2'b10, 6'b100010, 5'd0, 5'd1);
      step();
      check("sub_valid", {31'd0, out_valid}, 32'd1);
      check("sub_F", {28'd0, F}, 32'hA);
      check("sub_illegal", {31'd0, illegal}, 32'd0);
      check("sub_tag", {27'd0, tag_out}, 32'd1);
      in_valid = 1'b0;
      step();
      check("drain_valid", {31'd0, out_valid}, 32'd0);
      check("drain_F", {28'd0, F}, 32'd0);

      // sll then slt, back-to-back with simultaneous push/pop
      offer(2'b10, 6'b000000, 5'd7, 5'd2);
      step();
      check("sll_F", {28'd0, F}, 32'h4);
      check("sll_shamt", {27'd0, shamt}, 32'd7);
      offer(2'b10, 6'b101010, 5'd5, 5'd3);
      step();
      check("slt_F", {28'd0, F}, 32'hB);
      check("slt_shamt", {27'd0, shamt}, 32'd0);
      check("slt_tag", {27'd0, tag_out}, 32'd3);
      offer(2'b00, 6'b101010, 5'd5, 5'd4);
      step();
      check("add_F", {28'd0, F}, 32'h2);
      offer(2'b11, 6'b000000, 5'd5, 5'd5);
      step();
      check("ori_F", {28'd0, F}, 32'h1);
      check("ori_shamt", {27'd0, shamt}, 32'd0);
      offer(2'b10, 6'b100100, 5'd0, 5'd6);
      step();
      check("and_F", {28'd0, F}, 32'h0);
      check("and_valid", {31'd0, out_valid}, 32'd1);
      offer(2'b10, 6'b100111, 5'd0, 5'd7);
      step();
      check("bad_F", {28'd0, F}, 32'h2);
      check("bad_illegal", {31'd0, illegal}, 32'd1);
      in_valid = 1'b0;
      step();

      // fill to FULL under stall, then drain in order
      out_ready = 1'b0;
      offer(2'b00, 6'd0, 5'd0, 5'd3);
      step();
      check("fill1_ready", {31'd0, in_ready}, 32'd1);
      check("fill1_tag", {27'd0, tag_out}, 32'd3);
      offer(2'b01, 6'd0, 5'd0, 5'd4);
      step();
      check("full_ready", {31'd0, in_ready}, 32'd0);
      check("full_hold_tag", {27'd0, tag_out}, 32'd3);
      offer(2'b11, 6'd0, 5'd0, 5'd9);
      step();
      check("full_stall_tag", {27'd0, tag_out}, 32'd3);
      check("full_stall_F", {28'd0, F}, 32'h2);
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      check("pop2_tag", {27'd0, tag_out}, 32'd4);
      check("pop2_F", {28'd0, F}, 32'hA);
      check("pop2_ready", {31'd0, in_ready}, 32'd1);
      step();
      check("pop_empty_valid", {31'd0, out_valid}, 32'd0);

      // flush while FULL with a concurrent offer
      out_ready = 1'b0;
      offer(2'b00, 6'd0, 5'd0, 5'd6);
      step();
      offer(2'b00, 6'd0, 5'd0, 5'd7);
      step();
      check("pre_flush_ready", {31'd0, in_ready}, 32'd0);
      flush = 1'b1;
      out_ready = 1'b1;
      offer(2'b01, 6'd0, 5'd0, 5'd8);
      step();
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      check("flush_ready", {31'd0, in_ready}, 32'd1);
      check("flush_F", {28'd0, F}, 32'd0);
      flush = 1'b0;
      in_valid = 1'b0;
      step();
      check("flush_dropped", {31'd0, out_valid}, 32'd0);

      // sllv decode depends on build option
      rs_lo = 5'd9;
      offer(2'b10, 6'b000100, 5'd3, 5'd10);
      step();
`ifdef ALUCTRL_SLLV_EN
      check("sllv_F", {28'd0, F}, 32'h4);
      check("sllv_shamt", {27'd0, shamt}, 32'd9);
      check("sllv_illegal", {31'd0, illegal}, 32'd0);
`else
      check("sllv_F", {28'd0, F}, 32'h2);
      check("sllv_shamt", {27'd0, shamt}, 32'd0);
      check("sllv_illegal", {31'd0, illegal}, 32'd1);
`endif
      in_valid = 1'b0;
      step();

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      offer(2'b01, 6'd0, 5'd0, 5'd11);
      step();
      offer(2'b01, 6'd0, 5'd0, 5'd12);
      step();
      check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_F", {28'd0, F}, 32'd0);
      check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      step();
      reset = 1'b0;
      step();
      step();
      check("post_rst_valid", {31'd0, out_valid}, 32'd0);
      check("post_rst_ready", {31'd0, in_ready}, 32'd1);
      offer(2'b11, 6'd0, 5'd0, 5'd13);
      step();
      check("post_rst_push_valid", {31'd0, out_valid}, 32'd1);
      check("post_rst_push_tag", {27'd0, tag_out}, 32'd13);
      in_valid = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
